// File: rtl/change_dispenser_pkg.sv
// change_pkg: shared widths, coin denominations and FSM state type for the change dispenser.
package change_pkg;
    localparam int CHANGE_W = 16;
    localparam int NUM_DENOMS = 6;
    localparam int CNT_W = 8;
    localparam int INIT_COUNT = 10;
    localparam logic [7:0] DENOM_VAL [NUM_DENOMS] = '{8'd50, 8'd20, 8'd10, 8'd5, 8'd2, 8'd1};

    typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} chg_state_t;

    // dec is only ever set for a counter that is already nonzero, so the sum never goes negative
    function automatic logic [CNT_W-1:0] inv_next(logic [CNT_W-1:0] inv, logic dec, logic [CNT_W-1:0] add);
        logic [CNT_W:0] s;
        s = {1'b0, inv} - (CNT_W+1)'(dec) + {1'b0, add};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction
endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request, coin handshake, refill and completion signals of the dispenser.
interface change_dispenser_if;
    import change_pkg::*;
    logic change_valid;
    logic [CHANGE_W-1:0] change_amount;
    logic busy;
    logic drop_err;
    logic coin_valid;
    logic [2:0] coin_idx;
    logic [7:0] coin_value;
    logic coin_ready;
    logic refill_valid;
    logic [2:0] refill_idx;
    logic [CNT_W-1:0] refill_count;
    logic change_done;
    logic [CHANGE_W-1:0] shortfall;

    modport slave (
        input  change_valid, change_amount, coin_ready, refill_valid, refill_idx, refill_count,
        output busy, drop_err, coin_valid, coin_idx, coin_value, change_done, shortfall
    );
    modport master (
        output change_valid, change_amount, coin_ready, refill_valid, refill_idx, refill_count,
        input  busy, drop_err, coin_valid, coin_idx, coin_value, change_done, shortfall
    );
endinterface

// File: rtl/change_dispenser_denom_sel.sv
// change_denom_sel: picks the largest denomination (lowest index) that fits and is in stock.
module change_denom_sel
    import change_pkg::*;
(
    input  logic [CHANGE_W-1:0]   remaining_i,
    input  logic [NUM_DENOMS-1:0] avail_i,
    output logic                  found_o,
    output logic [2:0]            idx_o
);
    always_comb begin
        found_o = 1'b0;
        idx_o = '0;
        for (int i = NUM_DENOMS - 1; i >= 0; i--) begin
            if (avail_i[i] && CHANGE_W'(DENOM_VAL[i]) <= remaining_i) begin
                found_o = 1'b1;
                idx_o = 3'(i);
            end
        end
    end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount out as greedy coins, bounded by a per-denomination inventory.
module change_dispenser
    import change_pkg::*;
(
    input  logic clk,
    input  logic rst,
    change_dispenser_if.slave bus
);
    chg_state_t state_q, state_d;
    logic [CHANGE_W-1:0] rem_q, rem_d, short_q, short_d;
    logic [2:0] sel_q, sel_d, pick_idx;
    logic pick_found, drop_q, hs;
    logic [CNT_W-1:0] inv_q [NUM_DENOMS];
    logic [CNT_W-1:0] inv_d [NUM_DENOMS];
    logic [NUM_DENOMS-1:0] avail;

    change_denom_sel u_sel (
        .remaining_i(rem_q),
        .avail_i(avail),
        .found_o(pick_found),
        .idx_o(pick_idx)
    );

    assign hs = state_q == ISSUE && bus.coin_ready;
    assign bus.busy = state_q != IDLE;
    assign bus.coin_valid = state_q == ISSUE;
    assign bus.coin_idx = bus.coin_valid ? sel_q : '0;
    assign bus.coin_value = bus.coin_valid ? DENOM_VAL[sel_q] : '0;
    assign bus.change_done = state_q == DONE;
    assign bus.shortfall = short_q;
    assign bus.drop_err = drop_q;

    // availability comes from the registered counters, so a refill landing in SELECT counts next time
    always_comb begin
        for (int i = 0; i < NUM_DENOMS; i++) begin
            avail[i] = inv_q[i] != '0;
            inv_d[i] = inv_next(inv_q[i], hs && sel_q == 3'(i),
                                bus.refill_valid && bus.refill_idx == 3'(i) ? bus.refill_count : '0);
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d = rem_q;
        sel_d = sel_q;
        short_d = short_q;
        case (state_q)
            IDLE: begin
                state_d = bus.change_valid ? SELECT : IDLE;
                rem_d = bus.change_valid ? bus.change_amount : rem_q;
            end
            SELECT: begin
                state_d = pick_found ? ISSUE : DONE;
                sel_d = pick_found ? pick_idx : sel_q;
                short_d = pick_found ? short_q : rem_q;
            end
            ISSUE: begin
                state_d = bus.coin_ready ? SELECT : ISSUE;
                rem_d = bus.coin_ready ? rem_q - CHANGE_W'(DENOM_VAL[sel_q]) : rem_q;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q <= '0;
            short_q <= '0;
            sel_q <= '0;
            drop_q <= 1'b0;
            for (int i = 0; i < NUM_DENOMS; i++) inv_q[i] <= CNT_W'(INIT_COUNT);
        end else begin
            state_q <= state_d;
            rem_q <= rem_d;
            short_q <= short_d;
            sel_q <= sel_d;
            drop_q <= bus.change_valid && state_q != IDLE;
            inv_q <= inv_d;
        end
    end
endmodule
